hs32_reg_ctl: RTL and testbench
===============================

# hs32_reg_ctl

Register-file port controller for the HS32 core. It clears the 16×32 dual-port register file after reset, then shares its single write port between two writeback sources: ALU (wb0) and memory-load (wb1). It also schedules decode-stage reads around writes, because the register file captures read data only on cycles where `we` is low. It sits between decode/writeback and `hs32_reg` and drives every `hs32_reg` control input.

## Interface
- `WSTREAK`, default 4: maximum consecutive write-grant cycles while a read is pending.
- `INIT_CLEAR`, default 1: 1 = run the 16-cycle zero sweep after reset; 0 = go directly to RUN.
- `clk` in 1: core clock. One clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `rd_valid` in 1, `rd_ready` out 1: read request handshake.
- `rd_a1`, `rd_a2` in 4 each: read addresses.
- `rsp_valid` out 1: read-response strobe.
- `rsp_d1`, `rsp_d2` out 32 each: read data.
- `wb0_valid` in 1, `wb0_ready` out 1, `wb0_adr` in 4, `wb0_din` in 32: ALU writeback channel.
- `wb1_valid` in 1, `wb1_ready` out 1, `wb1_adr` in 4, `wb1_din` in 32: load writeback channel.
- `rf_we` out 1, `rf_wadr` out 4, `rf_din` out 32: register-file write port.
- `rf_radr1`, `rf_radr2` out 4: register-file read addresses.
- `rf_dout1`, `rf_dout2` in 32: register-file read data (registered inside the file).
- `busy` out 1: high while in INIT.

## Operation
**States**
- INIT: zero sweep.
- RUN: normal operation.
- Reset enters INIT if `INIT_CLEAR`=1, otherwise RUN.

**INIT**
- Drive `rf_we`=1, `rf_wadr`=`icnt`, `rf_din`=0.
- `icnt` counts 0→15; after the cycle with `icnt`=15, go to RUN.
- All ready outputs are 0 during INIT.

**RUN, one grant per cycle**
- Read is granted when `rd_valid` is high and either no wb channel is valid, or `streak`==`WSTREAK`.
- Otherwise, a write is granted when any wb channel is valid.

**Write arbitration (round-robin)**
- Two-entry arbiter with a `last` pointer.
- Only one channel valid: grant it.
- Both valid: grant the channel that is not `last`.
- On each write grant, `last` updates to the granted channel.
- Both channels targeting the same address are serialized in grant order; the later grant wins.

**Write grant**
- `rf_we`=1; `rf_wadr`/`rf_din` come from the granted channel.
- That channel's `wbN_ready`=1; the other channel's ready=0.

**Read grant**
- `rf_we`=0 and `rd_ready`=1.
- `rf_radr1`/`rf_radr2` = `rd_a1`/`rd_a2` at all times.

**Starvation counter (`streak`)**
- Increments on a write-grant cycle while `rd_valid`=1.
- Clears on a read grant, or on any cycle with `rd_valid`=0.
- Saturates at `WSTREAK`.

**Response and hazards**
- `rsp_d1`/`rsp_d2` = `rf_dout1`/`rf_dout2` passed straight through.
- `rsp_valid` is a registered copy of (`rd_valid` & `rd_ready`).
- Read-after-write needs no forwarding: a write committed at edge N is visible to a read granted in cycle N+1.

**Reset mid-operation**
- Asynchronous; abandons any sweep or in-flight response.
- `rsp_valid` drops immediately.
- The sweep restarts from `icnt`=0.

## Timing
**Reset values**
- State = INIT (or RUN), `icnt`=0, `streak`=0, `last`=wb1 (so wb0 wins the first tie), `rsp_valid`=0.
- `busy` = (`INIT_CLEAR`=1).
- `rd_ready`/`wb0_ready`/`wb1_ready` are combinational and are 0 in INIT.

**Latency**
- Read accepted in cycle N → `rsp_valid`=1 in N+1, with data for the addresses sampled in N.
- Response data is not held after N+1.
- Write accepted in cycle N → committed at the rising edge ending N.

**Throughput**
- One transaction per cycle.
- Sweep duration is exactly 16 cycles; first RUN cycle is cycle 16 after reset release.

**Handshakes**
- `ready` may depend combinationally on `valid`.
- Requesters hold `valid`, address and data stable until accepted.

## Structure
- Shared package/header `hs32_reg_pkg` holds:
  - state encoding (INIT, RUN),
  - `REG_COUNT`=16, `REG_AW`=4, `REG_DW`=32,
  - channel IDs (WB_ALU=0, WB_LD=1).
- Sub-module `hs32_rr_arb2`: two-request round-robin arbiter with the `last` pointer, reusable for bus arbitration.
- Counters, FSM and muxing stay in `hs32_reg_ctl`. `hs32_reg` is instantiated beside it at top level, not inside it.

## Test plan
- **Reset sweep:** release reset.
  - `rf_we`=1 for 16 cycles with `rf_wadr` 0..15 and `rf_din`=0.
  - `busy` falls at cycle 16; then reading r7 returns 0x00000000.
- **Write then read:** wb0 writes r3=0xDEADBEEF in cycle N; read r3/r3 requested in N+1.
  - `rsp_valid` in N+2 with `rsp_d1`=`rsp_d2`=0xDEADBEEF.
- **Round robin:** wb0 and wb1 both continuously valid, with r1=0x11 and r1=0x22.
  - Grants alternate wb0, wb1, wb0, …; after the final grant, r1 holds the last granted value.
- **Starvation:** `rd_valid` held while both wb channels stay valid, `WSTREAK`=4.
  - Exactly 4 write grants, then a read grant, then `streak`=0 and writes resume.
- **Idle read:** no writes, reads issued back-to-back.
  - `rd_ready`=1 every cycle; `rsp_valid` follows one cycle later.
- **Mid-sweep reset:** assert reset at `icnt`=9.
  - Outputs go to reset values asynchronously; after release the sweep restarts at `rf_wadr`=0.

Source files
------------

// File: rtl/hs32_reg_ctl_pkg.sv
// Shared definitions for the HS32 register-file port controller:
// FSM encoding, register-file geometry and writeback channel IDs.
package hs32_reg_pkg;

   localparam int REG_COUNT = 16;
   localparam int REG_AW    = 4;
   localparam int REG_DW    = 32;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctl_state_e;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_LD  = 1'b1
   } wb_id_e;

endpackage

// File: rtl/hs32_reg_ctl_if.sv
// Bundle of decode-read, writeback and register-file port signals
// around hs32_reg_ctl; slave is the controller side.
interface hs32_reg_ctl_if;
   import hs32_reg_pkg::*;

   logic              rd_valid;
   logic              rd_ready;
   logic [REG_AW-1:0] rd_a1;
   logic [REG_AW-1:0] rd_a2;

   logic              rsp_valid;
   logic [REG_DW-1:0] rsp_d1;
   logic [REG_DW-1:0] rsp_d2;

   logic              wb0_valid;
   logic              wb0_ready;
   logic [REG_AW-1:0] wb0_adr;
   logic [REG_DW-1:0] wb0_din;

   logic              wb1_valid;
   logic              wb1_ready;
   logic [REG_AW-1:0] wb1_adr;
   logic [REG_DW-1:0] wb1_din;

   logic              rf_we;
   logic [REG_AW-1:0] rf_wadr;
   logic [REG_DW-1:0] rf_din;
   logic [REG_AW-1:0] rf_radr1;
   logic [REG_AW-1:0] rf_radr2;
   logic [REG_DW-1:0] rf_dout1;
   logic [REG_DW-1:0] rf_dout2;

   modport slave (
      input  rd_valid, rd_a1, rd_a2,
      output rd_ready,
      output rsp_valid, rsp_d1, rsp_d2,
      input  wb0_valid, wb0_adr, wb0_din,
      output wb0_ready,
      input  wb1_valid, wb1_adr, wb1_din,
      output wb1_ready,
      output rf_we, rf_wadr, rf_din, rf_radr1, rf_radr2,
      input  rf_dout1, rf_dout2
   );

   modport master (
      output rd_valid, rd_a1, rd_a2,
      input  rd_ready,
      input  rsp_valid, rsp_d1, rsp_d2,
      output wb0_valid, wb0_adr, wb0_din,
      input  wb0_ready,
      output wb1_valid, wb1_adr, wb1_din,
      input  wb1_ready,
      input  rf_we, rf_wadr, rf_din, rf_radr1, rf_radr2,
      output rf_dout1, rf_dout2
   );

endinterface

// File: rtl/hs32_reg_ctl_arb2.sv
// Two-request round-robin arbiter; on a tie the request that was not
// granted last wins. The pointer only moves when en_i accepts a grant.
module hs32_rr_arb2
   import hs32_reg_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req0_i,
   input  logic req1_i,
   input  logic en_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   wb_id_e last_q;
   wb_id_e last_d;

   always_comb begin
      gnt1_o = req1_i & (~req0_i | (last_q == WB_ALU));
      gnt0_o = req0_i & ~gnt1_o;
      last_d = last_q;
      if (en_i && gnt1_o) begin
         last_d = WB_LD;
      end else if (en_i && gnt0_o) begin
         last_d = WB_ALU;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= WB_LD;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/hs32_reg_ctl.sv
// Register-file port controller: post-reset zero sweep, then one grant per
// cycle between a decode read and two round-robin writeback channels.
module hs32_reg_ctl
   import hs32_reg_pkg::*;
#(
   parameter int unsigned WSTREAK    = 4,
   parameter bit          INIT_CLEAR = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   hs32_reg_ctl_if.slave  bus,
   output logic           busy
);

   localparam int SW = $clog2(WSTREAK + 2);

   ctl_state_e        state_q, state_d;
   logic [REG_AW-1:0] icnt_q, icnt_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic              rsp_valid_q;
   logic              any_wb, rd_gnt, wr_gnt;
   logic              gnt0, gnt1;

   hs32_rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req0_i (bus.wb0_valid),
      .req1_i (bus.wb1_valid),
      .en_i   (wr_gnt),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1)
   );

   assign any_wb = bus.wb0_valid | bus.wb1_valid;

   always_comb begin
      state_d       = state_q;
      icnt_d        = icnt_q;
      streak_d      = streak_q;
      rd_gnt        = 1'b0;
      wr_gnt        = 1'b0;
      bus.rf_we     = 1'b0;
      bus.rf_wadr   = '0;
      bus.rf_din    = '0;
      bus.rd_ready  = 1'b0;
      bus.wb0_ready = 1'b0;
      bus.wb1_ready = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            bus.rf_we   = 1'b1;
            bus.rf_wadr = icnt_q;
            icnt_d      = icnt_q + 1'b1;
            if (icnt_q == REG_AW'(REG_COUNT - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A pending read only wins over writes once the streak saturates.
            rd_gnt = bus.rd_valid & (~any_wb | (streak_q == SW'(WSTREAK)));
            wr_gnt = ~rd_gnt & any_wb;
            bus.rd_ready = rd_gnt;
            if (wr_gnt) begin
               bus.rf_we     = 1'b1;
               bus.rf_wadr   = gnt1 ? bus.wb1_adr : bus.wb0_adr;
               bus.rf_din    = gnt1 ? bus.wb1_din : bus.wb0_din;
               bus.wb0_ready = gnt0;
               bus.wb1_ready = gnt1;
            end
            if (!bus.rd_valid || rd_gnt) begin
               streak_d = '0;
            end else if (wr_gnt && (streak_q != SW'(WSTREAK))) begin
               streak_d = streak_q + 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= INIT_CLEAR ? ST_INIT : ST_RUN;
         icnt_q      <= '0;
         streak_q    <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         icnt_q      <= icnt_d;
         streak_q    <= streak_d;
         rsp_valid_q <= bus.rd_valid & bus.rd_ready;
      end
   end

   assign bus.rf_radr1  = bus.rd_a1;
   assign bus.rf_radr2  = bus.rd_a2;
   assign bus.rsp_d1    = bus.rf_dout1;
   assign bus.rsp_d2    = bus.rf_dout2;
   assign bus.rsp_valid = rsp_valid_q;
   assign busy          = (state_q == ST_INIT);

endmodule

// File: tb/tb_hs32_reg_ctl.sv
// Directed bench for hs32_reg_ctl with a behavioural 16x32 register file
// that captures read data only on cycles with rf_we low.
module tb_hs32_reg_ctl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic busy;
   int   n_cmp = 0;
   int   n_err = 0;

   hs32_reg_ctl_if bus ();

   hs32_reg_ctl #(.WSTREAK(4), .INIT_CLEAR(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [16];
   always @(posedge clk) begin
      if (bus.rf_we) begin
         mem[bus.rf_wadr] <= bus.rf_din;
      end else begin
         bus.rf_dout1 <= mem[bus.rf_radr1];
         bus.rf_dout2 <= mem[bus.rf_radr2];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.rd_valid  = 1'b0; bus.rd_a1 = '0; bus.rd_a2 = '0;
      bus.wb0_valid = 1'b0; bus.wb0_adr = '0; bus.wb0_din = '0;
      bus.wb1_valid = 1'b0; bus.wb1_adr = '0; bus.wb1_din = '0;
   endtask

   task automatic test_reset;
      idle_inputs();
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %0b exp 1", busy); end
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0b exp 0", bus.rsp_valid); end
      n_cmp++; if (bus.rf_wadr !== 4'd0) begin n_err++; $display("FAIL reset_wadr got %0d exp 0", bus.rf_wadr); end
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_sweep;
      bus.rd_valid  = 1'b1;
      bus.wb0_valid = 1'b1; bus.wb0_adr = 4'd2; bus.wb0_din = 32'hFFFF_FFFF;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_cmp++; if (bus.rf_we !== 1'b1) begin n_err++; $display("FAIL sweep_we[%0d] got %0b exp 1", i, bus.rf_we); end
         n_cmp++; if (bus.rf_wadr !== 4'(i)) begin n_err++; $display("FAIL sweep_wadr[%0d] got %0d exp %0d", i, bus.rf_wadr, i); end
         n_cmp++; if (bus.rf_din !== 32'h0) begin n_err++; $display("FAIL sweep_din[%0d] got %h exp 0", i, bus.rf_din); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sweep_busy[%0d] got %0b exp 1", i, busy); end
         n_cmp++; if ({bus.rd_ready, bus.wb0_ready, bus.wb1_ready} !== 3'b000) begin n_err++; $display("FAIL sweep_ready[%0d] got %b exp 000", i, {bus.rd_ready, bus.wb0_ready, bus.wb1_ready}); end
         tick();
      end
      idle_inputs();
      bus.rd_valid = 1'b1; bus.rd_a1 = 4'd7; bus.rd_a2 = 4'd7;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_busy_fall got %0b exp 0", busy); end
      n_cmp++; if (bus.rd_ready !== 1'b1) begin n_err++; $display("FAIL sweep_r7_ready got %0b exp 1", bus.rd_ready); end
      tick();
      bus.rd_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL sweep_r7_rsp_valid got %0b exp 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_d1 !== 32'h0) begin n_err++; $display("FAIL sweep_r7_data got %h exp 00000000", bus.rsp_d1); end
      tick();
   endtask

   // After reset last=wb1, so a tie goes wb0 first; five grants end on wb0.
   task automatic test_round_robin;
      logic [4:0] exp_g1;
      exp_g1 = 5'b01010;
      bus.wb0_valid = 1'b1; bus.wb0_adr = 4'd1; bus.wb0_din = 32'h11;
      bus.wb1_valid = 1'b1; bus.wb1_adr = 4'd1; bus.wb1_din = 32'h22;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if ({bus.wb1_ready, bus.wb0_ready} !== {exp_g1[i], ~exp_g1[i]}) begin n_err++; $display("FAIL rr_grant[%0d] got w1w0=%b exp %b", i, {bus.wb1_ready, bus.wb0_ready}, {exp_g1[i], ~exp_g1[i]}); end
         n_cmp++; if (bus.rf_din !== (exp_g1[i] ? 32'h22 : 32'h11)) begin n_err++; $display("FAIL rr_din[%0d] got %h exp %h", i, bus.rf_din, exp_g1[i] ? 32'h22 : 32'h11); end
         tick();
      end
      idle_inputs();
      bus.rd_valid = 1'b1; bus.rd_a1 = 4'd1; bus.rd_a2 = 4'd1;
      tick();
      bus.rd_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.rsp_d1 !== 32'h11) begin n_err++; $display("FAIL rr_final_r1 got %h exp 00000011", bus.rsp_d1); end
      tick();
   endtask

   task automatic test_write_read;
      bus.wb0_valid = 1'b1; bus.wb0_adr = 4'd3; bus.wb0_din = 32'hDEADBEEF;
      @(negedge clk);
      n_cmp++; if ({bus.rf_we, bus.wb0_ready, bus.rf_wadr} !== {1'b1, 1'b1, 4'd3}) begin n_err++; $display("FAIL wr_grant got we/rdy/adr=%b/%b/%0d exp 1/1/3", bus.rf_we, bus.wb0_ready, bus.rf_wadr); end
      n_cmp++; if (bus.rf_din !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_din got %h exp deadbeef", bus.rf_din); end
      tick();
      idle_inputs();
      bus.rd_valid = 1'b1; bus.rd_a1 = 4'd3; bus.rd_a2 = 4'd3;
      @(negedge clk);
      n_cmp++; if ({bus.rd_ready, bus.rf_we} !== 2'b10) begin n_err++; $display("FAIL raw_read_grant got rdy/we=%b exp 10", {bus.rd_ready, bus.rf_we}); end
      tick();
      bus.rd_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL raw_rsp_valid got %0b exp 1", bus.rsp_valid); end
      n_cmp++; if (bus.rsp_d1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_d1 got %h exp deadbeef", bus.rsp_d1); end
      n_cmp++; if (bus.rsp_d2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL raw_d2 got %h exp deadbeef", bus.rsp_d2); end
      tick();
      @(negedge clk);
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL raw_rsp_not_held got %0b exp 0", bus.rsp_valid); end
      tick();
   endtask

   // last=wb0 here: four writes wb1,wb0,wb1,wb0, a forced read, then wb1 resumes.
   task automatic test_starvation;
      logic [5:0] exp_rd, exp_w1, exp_w0;
      exp_rd = 6'b010000; exp_w1 = 6'b100101; exp_w0 = 6'b001010;
      bus.rd_valid = 1'b1; bus.rd_a1 = 4'd1; bus.rd_a2 = 4'd3;
      bus.wb0_valid = 1'b1; bus.wb0_adr = 4'd5; bus.wb0_din = 32'h55;
      bus.wb1_valid = 1'b1; bus.wb1_adr = 4'd6; bus.wb1_din = 32'h66;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++; if ({bus.rd_ready, bus.wb1_ready, bus.wb0_ready, bus.rf_we} !== {exp_rd[i], exp_w1[i], exp_w0[i], ~exp_rd[i]}) begin n_err++; $display("FAIL starve[%0d] got rd/w1/w0/we=%b exp %b", i, {bus.rd_ready, bus.wb1_ready, bus.wb0_ready, bus.rf_we}, {exp_rd[i], exp_w1[i], exp_w0[i], ~exp_rd[i]}); end
         if (i == 5) begin
            n_cmp++; if ({bus.rsp_valid, bus.rsp_d1, bus.rsp_d2} !== {1'b1, 32'h11, 32'hDEADBEEF}) begin n_err++; $display("FAIL starve_rsp got v=%0b d1=%h d2=%h exp 1/00000011/deadbeef", bus.rsp_valid, bus.rsp_d1, bus.rsp_d2); end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_back_to_back;
      logic [3:0]  a1 [4];
      logic [3:0]  a2 [4];
      logic [31:0] e1 [4];
      logic [31:0] e2 [4];
      a1 = '{4'd1, 4'd5, 4'd6, 4'd3};
      a2 = '{4'd3, 4'd6, 4'd5, 4'd1};
      e1 = '{32'h11, 32'h55, 32'h66, 32'hDEADBEEF};
      e2 = '{32'hDEADBEEF, 32'h66, 32'h55, 32'h11};
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            bus.rd_valid = 1'b1; bus.rd_a1 = a1[i]; bus.rd_a2 = a2[i];
         end else begin
            bus.rd_valid = 1'b0;
         end
         @(negedge clk);
         if (i < 4) begin
            n_cmp++; if (bus.rd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %0b exp 1", i, bus.rd_ready); end
         end
         n_cmp++; if (bus.rsp_valid !== (i > 0 && i < 5)) begin n_err++; $display("FAIL b2b_rsp_valid[%0d] got %0b exp %0b", i, bus.rsp_valid, (i > 0 && i < 5)); end
         if (i > 0 && i < 5) begin
            n_cmp++; if ({bus.rsp_d1, bus.rsp_d2} !== {e1[i-1], e2[i-1]}) begin n_err++; $display("FAIL b2b_data[%0d] got %h/%h exp %h/%h", i - 1, bus.rsp_d1, bus.rsp_d2, e1[i-1], e2[i-1]); end
         end
         tick();
      end
   endtask

   task automatic test_mid_reset;
      bus.rd_valid = 1'b1; bus.rd_a1 = 4'd3; bus.rd_a2 = 4'd3;
      tick();
      bus.rd_valid = 1'b0;
      #2;
      n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL mr_rsp_before got %0b exp 1", bus.rsp_valid); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({bus.rsp_valid, busy, bus.rf_we, bus.rf_wadr} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin n_err++; $display("FAIL mr_async_run got v/busy/we/adr=%b exp 0/1/1/0", {bus.rsp_valid, busy, bus.rf_we, bus.rf_wadr}); end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      @(negedge clk);
      n_cmp++; if (bus.rf_wadr !== 4'd9) begin n_err++; $display("FAIL mr_icnt9 got %0d exp 9", bus.rf_wadr); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({busy, bus.rf_we, bus.rf_wadr} !== {1'b1, 1'b1, 4'd0}) begin n_err++; $display("FAIL mr_async_sweep got busy/we/adr=%b exp 1/1/0", {busy, bus.rf_we, bus.rf_wadr}); end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_cmp++; if ({busy, bus.rf_wadr} !== {1'b1, 4'(i)}) begin n_err++; $display("FAIL mr_resweep[%0d] got busy/adr=%0b/%0d exp 1/%0d", i, busy, bus.rf_wadr, i); end
         tick();
      end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mr_busy_fall got %0b exp 0", busy); end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_round_robin();
      test_write_read();
      test_starvation();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
